// File: rtl/ssit.sv
// rtl/ssit.sv - store set ID table: 4-wide PC-to-SSID lookup with violation training and cyclic clear
//
// Ports:
//   clock, reset_n                      rising-edge clock, synchronous active-low reset
//   pcN_in, reqN_in (N=0..3)            lookup PC index and request per bundle slot
//   ssidN_out, validN_out               combinational lookup result per slot
//   train_valid_in, train_load_pc_in,   violation report (valid/ready handshake)
//   train_store_pc_in, train_ready_out
//   clear_pulse_out                     high in the cycle the flash clear takes effect

module ssit #(
    parameter int IDX_BITS       = 10,
    parameter int SSID_BITS      = 7,
    parameter int CLEAR_INTERVAL = 16384
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [IDX_BITS-1:0]  pc0_in,
    input  logic [IDX_BITS-1:0]  pc1_in,
    input  logic [IDX_BITS-1:0]  pc2_in,
    input  logic [IDX_BITS-1:0]  pc3_in,
    input  logic                 req0_in,
    input  logic                 req1_in,
    input  logic                 req2_in,
    input  logic                 req3_in,
    output logic [SSID_BITS-1:0] ssid0_out,
    output logic [SSID_BITS-1:0] ssid1_out,
    output logic [SSID_BITS-1:0] ssid2_out,
    output logic [SSID_BITS-1:0] ssid3_out,
    output logic                 valid0_out,
    output logic                 valid1_out,
    output logic                 valid2_out,
    output logic                 valid3_out,
    input  logic                 train_valid_in,
    input  logic [IDX_BITS-1:0]  train_load_pc_in,
    input  logic [IDX_BITS-1:0]  train_store_pc_in,
    output logic                 train_ready_out,
    output logic                 clear_pulse_out
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam int CLR_W = $clog2(CLEAR_INTERVAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [SSID_BITS-1:0] ssid_mem [DEPTH];
    logic [DEPTH-1:0]     vbit_q;

    logic [IDX_BITS-1:0]  ld_pc_q;
    logic [IDX_BITS-1:0]  st_pc_q;
    logic                 lv_q;
    logic                 ls_q;
    logic [SSID_BITS-1:0] l_q;
    logic [SSID_BITS-1:0] s_q;

    logic [SSID_BITS-1:0] alloc_q;
    logic [CLR_W-1:0]     clr_cnt_q;
    logic                 clear_now;

    logic                 wr_en;
    logic                 wr_ld;
    logic                 wr_st;
    logic                 do_alloc;
    logic [SSID_BITS-1:0] wr_val;

    assign clear_now = (clr_cnt_q == CLR_W'(CLEAR_INTERVAL - 1));

    // A clear coinciding with the write cycle drops the training update.
    assign wr_en = (state_q == S_WRITE) && !clear_now;

    // Lookups read the arrays as they stand before this cycle's write.
    assign ssid0_out  = ssid_mem[pc0_in];
    assign ssid1_out  = ssid_mem[pc1_in];
    assign ssid2_out  = ssid_mem[pc2_in];
    assign ssid3_out  = ssid_mem[pc3_in];
    assign valid0_out = reset_n && vbit_q[pc0_in] && req0_in;
    assign valid1_out = reset_n && vbit_q[pc1_in] && req1_in;
    assign valid2_out = reset_n && vbit_q[pc2_in] && req2_in;
    assign valid3_out = reset_n && vbit_q[pc3_in] && req3_in;

    assign train_ready_out = !reset_n || (state_q == S_IDLE);
    assign clear_pulse_out = reset_n && clear_now;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (train_valid_in) state_d = S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Merge rule. When load and store PCs match, lv/ls and l/s come from the
    // same entry, so the same cases collapse to a single-entry update.
    always_comb begin
        wr_ld    = 1'b0;
        wr_st    = 1'b0;
        do_alloc = 1'b0;
        wr_val   = alloc_q;
        unique case ({lv_q, ls_q})
            2'b00: begin
                do_alloc = 1'b1;
                wr_ld    = 1'b1;
                wr_st    = 1'b1;
                wr_val   = alloc_q;
            end
            2'b10: begin
                wr_st  = 1'b1;
                wr_val = l_q;
            end
            2'b01: begin
                wr_ld  = 1'b1;
                wr_val = s_q;
            end
            default: begin
                wr_ld  = 1'b1;
                wr_st  = 1'b1;
                wr_val = (l_q < s_q) ? l_q : s_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            vbit_q    <= '0;
            alloc_q   <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (clear_now) begin
                clr_cnt_q <= '0;
                vbit_q    <= '0;
            end else begin
                clr_cnt_q <= clr_cnt_q + CLR_W'(1);
                if (wr_en && wr_ld) vbit_q[ld_pc_q] <= 1'b1;
                if (wr_en && wr_st) vbit_q[st_pc_q] <= 1'b1;
            end
            if (wr_en && do_alloc) alloc_q <= alloc_q + SSID_BITS'(1);
        end
    end

    // Capture registers need no reset: they are only consumed in READ/WRITE,
    // which are always entered through an accepted report.
    always_ff @(posedge clock) begin
        if (state_q == S_IDLE && train_valid_in) begin
            ld_pc_q <= train_load_pc_in;
            st_pc_q <= train_store_pc_in;
        end
        if (state_q == S_READ) begin
            lv_q <= vbit_q[ld_pc_q];
            ls_q <= vbit_q[st_pc_q];
            l_q  <= ssid_mem[ld_pc_q];
            s_q  <= ssid_mem[st_pc_q];
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && wr_en) begin
            if (wr_ld) ssid_mem[ld_pc_q] <= wr_val;
            if (wr_st) ssid_mem[st_pc_q] <= wr_val;
        end
    end

endmodule

// File: tb/tb_ssit.sv
// tb/tb_ssit.sv - scoreboard bench for ssit

module tb_ssit;

    localparam int K_VALID = 0;
    localparam int K_SSID  = 1;
    localparam int K_READY = 2;
    localparam int K_PULSE = 3;

    typedef struct {
        int    cyc;
        int    d;
        int    k;
        int    s;
        int    exp;
        string nm;
    } exp_t;

    logic       clock;
    int         cyc;
    logic       rst_n [2];
    logic [9:0] pc_s [2][4];
    logic       req_s [2][4];
    logic [6:0] ssid_s [2][4];
    logic       valid_s [2][4];
    logic       tv [2];
    logic [9:0] tl [2];
    logic [9:0] ts [2];
    logic       rdy [2];
    logic       pul [2];

    exp_t        sb [$];
    exp_t        e;
    logic [31:0] act;
    int          n_cmp;
    int          n_bad;

    ssit #(.IDX_BITS(10), .SSID_BITS(7), .CLEAR_INTERVAL(16384)) dut (
        .clock(clock), .reset_n(rst_n[0]),
        .pc0_in(pc_s[0][0]), .pc1_in(pc_s[0][1]), .pc2_in(pc_s[0][2]), .pc3_in(pc_s[0][3]),
        .req0_in(req_s[0][0]), .req1_in(req_s[0][1]), .req2_in(req_s[0][2]), .req3_in(req_s[0][3]),
        .ssid0_out(ssid_s[0][0]), .ssid1_out(ssid_s[0][1]), .ssid2_out(ssid_s[0][2]), .ssid3_out(ssid_s[0][3]),
        .valid0_out(valid_s[0][0]), .valid1_out(valid_s[0][1]), .valid2_out(valid_s[0][2]), .valid3_out(valid_s[0][3]),
        .train_valid_in(tv[0]), .train_load_pc_in(tl[0]), .train_store_pc_in(ts[0]),
        .train_ready_out(rdy[0]), .clear_pulse_out(pul[0])
    );

    ssit #(.IDX_BITS(10), .SSID_BITS(7), .CLEAR_INTERVAL(8)) dut_clr (
        .clock(clock), .reset_n(rst_n[1]),
        .pc0_in(pc_s[1][0]), .pc1_in(pc_s[1][1]), .pc2_in(pc_s[1][2]), .pc3_in(pc_s[1][3]),
        .req0_in(req_s[1][0]), .req1_in(req_s[1][1]), .req2_in(req_s[1][2]), .req3_in(req_s[1][3]),
        .ssid0_out(ssid_s[1][0]), .ssid1_out(ssid_s[1][1]), .ssid2_out(ssid_s[1][2]), .ssid3_out(ssid_s[1][3]),
        .valid0_out(valid_s[1][0]), .valid1_out(valid_s[1][1]), .valid2_out(valid_s[1][2]), .valid3_out(valid_s[1][3]),
        .train_valid_in(tv[1]), .train_load_pc_in(tl[1]), .train_store_pc_in(ts[1]),
        .train_ready_out(rdy[1]), .clear_pulse_out(pul[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int d, int k, int s);
        case (k)
            K_VALID: return {31'b0, valid_s[d][s]};
            K_SSID:  return {25'b0, ssid_s[d][s]};
            K_READY: return {31'b0, rdy[d]};
            default: return {31'b0, pul[d]};
        endcase
    endfunction

    // Monitor: compares every expectation scheduled for the current cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.d, e.k, e.s);
            n_cmp++;
            if (e.cyc != cyc || act !== 32'(e.exp)) begin
                n_bad++;
                $display("FAIL %s: dut%0d kind%0d slot%0d cycle%0d got %0d expected %0d",
                         e.nm, e.d, e.k, e.s, e.cyc, act, e.exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push(int d, int k, int s, int ex, string nm);
        sb.push_back('{cyc: cyc, d: d, k: k, s: s, exp: ex, nm: nm});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // es < 0 means only validity is checked.
    task automatic look(int d, int slot, int pc, bit req, bit ev, int es, string nm);
        pc_s[d][slot]  = 10'(pc);
        req_s[d][slot] = req;
        push(d, K_VALID, slot, int'(ev), nm);
        if (ev && es >= 0) push(d, K_SSID, slot, es, nm);
    endtask

    task automatic expect_ctl(int d, bit er, bit ep, string nm);
        push(d, K_READY, 0, int'(er), nm);
        push(d, K_PULSE, 0, int'(ep), nm);
    endtask

    // Presents a report in the current cycle (T); returns in cycle T+1.
    task automatic train_start(int d, int ld, int st);
        push(d, K_READY, 0, 1, "accept_ready");
        tv[d] = 1'b1;
        tl[d] = 10'(ld);
        ts[d] = 10'(st);
        step();
        tv[d] = 1'b0;
    endtask

    // Returns in cycle T+3, when the update is visible.
    task automatic train_full(int d, int ld, int st);
        train_start(d, ld, st);
        step();
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            tv[d]    = 1'b0;
            tl[d]    = '0;
            ts[d]    = '0;
            for (int s = 0; s < 4; s++) begin
                pc_s[d][s]  = '0;
                req_s[d][s] = 1'b0;
            end
        end

        // Reset behaviour
        step();
        step();
        look(0, 0, 5, 1, 0, 0, "rst_valid0");
        expect_ctl(0, 1, 0, "rst_ctl");
        step();
        rst_n[0] = 1'b1;
        look(0, 0, 5, 1, 0, 0, "post_rst_valid0");
        expect_ctl(0, 1, 0, "post_rst_ctl");

        // First allocation, busy window
        train_start(0, 10, 20);
        push(0, K_READY, 0, 0, "busy_t1");
        step();
        push(0, K_READY, 0, 0, "busy_t2");
        step();
        look(0, 0, 10, 1, 1, 0, "alloc0_ld");
        look(0, 1, 20, 1, 1, 0, "alloc0_st");
        train_full(0, 60, 70);
        look(0, 0, 60, 1, 1, 1, "alloc1_ld");
        look(0, 1, 70, 1, 1, 1, "alloc1_st");
        train_full(0, 80, 80);
        look(0, 0, 80, 1, 1, 2, "alloc_same_pc");
        train_full(0, 90, 91);
        look(0, 0, 90, 1, 1, 3, "alloc3_ld");

        // One side valid
        train_full(0, 90, 30);
        look(0, 1, 30, 1, 1, 3, "store_takes_L");
        train_full(0, 100, 101);
        look(0, 0, 100, 1, 1, 4, "alloc_unchanged");
        train_full(0, 110, 90);
        look(0, 2, 110, 1, 1, 3, "load_takes_S");

        // Both valid: min wins
        for (int k = 0; k < 5; k++) train_full(0, 120 + k, 120 + k);
        look(0, 0, 124, 1, 1, 9, "alloc9");
        train_full(0, 124, 100);
        look(0, 0, 124, 1, 1, 4, "min_ld_gets_S");
        look(0, 1, 100, 1, 1, 4, "min_st_keeps_S");
        train_full(0, 20, 123);
        look(0, 0, 123, 1, 1, 0, "min_st_gets_L");
        train_full(0, 80, 80);
        look(0, 0, 80, 1, 1, 2, "same_pc_valid");
        train_full(0, 130, 131);
        look(0, 0, 130, 1, 1, 10, "alloc10");

        // Request gating
        look(0, 1, 10, 0, 0, 0, "req_gate");
        step();
        req_s[0][1] = 1'b1;

        // Lookup in the write cycle returns the old value
        train_start(0, 150, 101);
        step();
        look(0, 2, 150, 1, 0, 0, "wcycle_old_inv");
        step();
        look(0, 2, 150, 1, 1, 4, "wcycle_new_inv");
        train_start(0, 10, 100);
        step();
        look(0, 3, 100, 1, 1, 4, "wcycle_old_val");
        step();
        look(0, 3, 100, 1, 1, 0, "wcycle_new_val");

        // Alloc counter wrap
        for (int i = 11; i < 128; i++) train_full(0, 200 + i, 200 + i);
        look(0, 0, 327, 1, 1, 127, "alloc127");
        train_full(0, 400, 400);
        look(0, 0, 400, 1, 1, 0, "alloc_wrap");

        // Reset during READ
        train_start(0, 500, 501);
        rst_n[0] = 1'b0;
        step();
        expect_ctl(0, 1, 0, "rst_in_read_ctl");
        look(0, 0, 400, 1, 0, 0, "rst_in_read_valid");
        rst_n[0] = 1'b1;
        step();
        expect_ctl(0, 1, 0, "after_rst_ctl");
        step();
        step();
        look(0, 0, 500, 1, 0, 0, "rst_drop_ld");
        look(0, 1, 501, 1, 0, 0, "rst_drop_st");
        train_full(0, 500, 501);
        look(0, 0, 500, 1, 1, 0, "alloc_after_rst");

        // Cyclic clear on the short-interval instance; base = cycle with counter 0
        rst_n[1] = 1'b0;
        step();
        rst_n[1] = 1'b1;
        expect_ctl(1, 1, 0, "clr_base");
        step();
        train_start(1, 10, 20);
        step();
        step();
        look(1, 0, 10, 1, 1, 0, "clr_pre");
        step();
        train_start(1, 30, 31);
        expect_ctl(1, 0, 0, "clr_read_cycle");
        step();
        expect_ctl(1, 0, 1, "clr_on_write");
        step();
        expect_ctl(1, 1, 0, "clr_after");
        look(1, 0, 10, 1, 0, 0, "clr_flushed");
        look(1, 1, 30, 1, 0, 0, "clr_drop_ld");
        look(1, 2, 31, 1, 0, 0, "clr_drop_st");
        step();
        train_full(1, 40, 41);
        look(1, 0, 40, 1, 1, -1, "clr_retrain");
        step();
        step();
        train_start(1, 40, 50);
        expect_ctl(1, 0, 1, "clr_on_read");
        step();
        expect_ctl(1, 0, 0, "clr_read_write");
        step();
        look(1, 0, 50, 1, 1, -1, "clr_read_keeps_lv");
        look(1, 1, 40, 1, 0, 0, "clr_read_ld_cleared");

        step();
        step();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
